ram16_bus_bridge: RTL and testbench

Bridge between the CPU's 32-bit byte-addressed memory bus (read/write/waitrequest) and the 16-bit × 4096 test RAM.
- Each word access becomes two sequential halfword accesses: low halfword first, then high.
- Partial writes use single-cycle read-modify-write; this relies on the RAM's combinational read path.
- Sits directly upstream of the RAM in the testbench memory subsystem.

---
 rtl/ram16_bus_pkg.sv | 19 +
 rtl/ram16_bus_bridge_halfword_merge.sv | 13 +
 rtl/ram16_bus_bridge.sv | 130 +++++++++++++
 tb/tb_ram16_bus_bridge.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram16_bus_pkg.sv
// Shared types and constants for the 32-bit bus to 16-bit test RAM bridge.
package ram16_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_ADDR_BASE = 32'hBFC00000;
  localparam int          DEFAULT_RAM_DEPTH = 4096;

  function automatic logic [31:0] halfword_index(input logic [31:0] addr,
                                                 input logic [31:0] base);
    return (addr - base) >> 1;
  endfunction

endpackage

// File: rtl/ram16_bus_bridge_halfword_merge.sv
// Byte-lane merge of new write data over old RAM contents; purely combinational.
// Zero latency, no flow control.
module halfword_merge (
  input  logic [15:0] old,
  input  logic [15:0] new_dat,
  input  logic [1:0]  be,
  output logic [15:0] merged
);

  assign merged[7:0]  = be[0] ? new_dat[7:0]  : old[7:0];
  assign merged[15:8] = be[1] ? new_dat[15:8] : old[15:8];

endmodule

// File: rtl/ram16_bus_bridge.sv
// Splits each 32-bit CPU access into low then high 16-bit RAM accesses (RMW for partial writes).
// Fixed 4-cycle latency (2 on error); waitrequest holds the CPU until DONE.
module ram16_bus_bridge
  import ram16_bus_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = DEFAULT_ADDR_BASE,
  parameter int          RAM_DEPTH = DEFAULT_RAM_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        addr_error,
  output logic [31:0] ram_address,
  output logic        ram_read,
  output logic        ram_write,
  output logic [31:0] ram_writedata,
  input  logic [31:0] ram_readdata
);

  localparam logic [31:0] DEPTH_W = RAM_DEPTH;

  state_t      state, state_nxt;
  logic [31:0] h_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        is_wr_q;

  logic        req;
  logic [31:0] h_in;
  logic        bad;
  logic        hi_sel;
  logic [15:0] m_new;
  logic [1:0]  m_be;
  logic [15:0] merged;
  logic        unused_ok;

  assign req       = read | write;
  assign h_in      = halfword_index(address, ADDR_BASE);
  // Addresses below ADDR_BASE wrap to a huge index and fall out of range here.
  assign bad       = (address[1:0] != 2'b00) || ((h_in + 32'd1) >= DEPTH_W) || (read && write);
  assign unused_ok = ^ram_readdata[31:16];

  assign hi_sel = (state == HI);
  assign m_new  = hi_sel ? wdata_q[31:16] : wdata_q[15:0];
  assign m_be   = hi_sel ? be_q[3:2]      : be_q[1:0];

  halfword_merge u_merge (
    .old     (ram_readdata[15:0]),
    .new_dat (m_new),
    .be      (m_be),
    .merged  (merged)
  );

  always_comb begin
    state_nxt     = state;
    waitrequest   = 1'b1;
    ram_address   = 32'd0;
    ram_read      = 1'b0;
    ram_write     = 1'b0;
    ram_writedata = 32'd0;
    case (state)
      IDLE: begin
        waitrequest = req;
        if (req) state_nxt = bad ? DONE : LO;
      end
      LO: begin
        ram_address   = h_q;
        ram_read      = 1'b1;
        ram_write     = is_wr_q && (m_be != 2'b00);
        ram_writedata = {16'h0000, merged};
        state_nxt     = HI;
      end
      HI: begin
        ram_address   = h_q + 32'd1;
        ram_read      = 1'b1;
        ram_write     = is_wr_q && (m_be != 2'b00);
        ram_writedata = {16'h0000, merged};
        state_nxt     = DONE;
      end
      DONE: begin
        waitrequest = 1'b0;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset must never let a half-finished write reach the RAM.
    if (reset) begin
      waitrequest = 1'b1;
      ram_write   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      h_q        <= 32'd0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      is_wr_q    <= 1'b0;
      readdata   <= 32'd0;
      addr_error <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req) begin
            h_q     <= h_in;
            be_q    <= byteenable;
            wdata_q <= writedata;
            is_wr_q <= write;
            if (bad) begin
              addr_error <= 1'b1;
              readdata   <= 32'd0;
            end
          end
        end
        LO: if (!is_wr_q) readdata[15:0]  <= ram_readdata[15:0];
        HI: if (!is_wr_q) readdata[31:16] <= ram_readdata[15:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram16_bus_bridge.sv
// Self-checking bench: RAM array on the downstream side, scoreboard of expected readdata.
module tb_ram16_bus_bridge;

  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam int          DEPTH = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        addr_error;
  logic [31:0] ram_address;
  logic        ram_read;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata;

  logic [15:0] mem     [DEPTH];
  logic [15:0] ref_mem [DEPTH];
  logic [31:0] exp_q   [$];
  logic [31:0] model_rd;
  int          checks = 0;
  int          errors = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  longint      last_done_t;

  always #5 clk = ~clk;

  ram16_bus_bridge #(.ADDR_BASE(BASE), .RAM_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .write         (write),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .addr_error    (addr_error),
    .ram_address   (ram_address),
    .ram_read      (ram_read),
    .ram_write     (ram_write),
    .ram_writedata (ram_writedata),
    .ram_readdata  (ram_readdata)
  );

  // RAM with combinational read, registered write.
  assign ram_readdata = {16'h0000, mem[ram_address[11:0]]};
  always @(posedge clk) if (ram_write) mem[ram_address[11:0]] <= ram_writedata[15:0];

  always @(negedge clk) begin
    if (ram_read)  rd_cnt <= rd_cnt + 1;
    if (ram_write) wr_cnt <= wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] merge16(input logic [15:0] o, input logic [15:0] n,
                                          input logic [1:0] b);
    merge16 = o;
    if (b[0]) merge16[7:0]  = n[7:0];
    if (b[1]) merge16[15:8] = n[15:8];
  endfunction

  // Starts #1 after a rising edge (cycle 0); returns #1 after the edge that ends DONE.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] off, input logic [3:0] be,
                        input logic [31:0] wd, input bit keep);
    logic [31:0] h;
    logic [31:0] exp_rd;
    bit          bad;
    bit          done;
    int          cyc;
    int          exp_lat;
    h       = off >> 1;
    bad     = (off[1:0] != 2'b00) || (h + 32'd1 >= DEPTH) || (rd && wr);
    exp_lat = bad ? 1 : 3;
    if (bad)     exp_rd = 32'd0;
    else if (rd) exp_rd = {ref_mem[h + 1], ref_mem[h]};
    else begin
      exp_rd = model_rd;
      ref_mem[h]     = merge16(ref_mem[h],     wd[15:0],  be[1:0]);
      ref_mem[h + 1] = merge16(ref_mem[h + 1], wd[31:16], be[3:2]);
    end
    model_rd = exp_rd;
    exp_q.push_back(exp_rd);

    address    = BASE + off;
    read       = rd;
    write      = wr;
    byteenable = be;
    writedata  = wd;
    done = 0;
    cyc  = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!waitrequest) begin
        done = 1;
        cyc  = c;
        break;
      end
    end
    if (!done) begin
      chk({tag, "_timeout"}, {31'd0, waitrequest}, 32'd0);
      void'(exp_q.pop_front());
    end else begin
      last_done_t = $time;
      chk({tag, "_lat"}, cyc, exp_lat);
      chk({tag, "_rdata"}, readdata, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      read  = 1'b0;
      write = 1'b0;
    end
  endtask

  initial begin
    int     rd0, wr0;
    longint t1;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    model_rd   = 32'd0;
    reset      = 1'b1;
    address    = 32'd0;
    read       = 1'b0;
    write      = 1'b0;
    byteenable = 4'd0;
    writedata  = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wait",  {31'd0, waitrequest}, 32'd1);
    chk("rst_rdata", readdata, 32'd0);
    chk("rst_err",   {31'd0, addr_error}, 32'd0);
    chk("rst_ram",   {29'd0, ram_read, ram_write, |ram_address}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_wait", {31'd0, waitrequest}, 32'd0);
    @(posedge clk);
    #1;

    // Full-word write then read.
    access("wr_full", 1'b0, 1'b1, 32'd8, 4'hF, 32'hDEADBEEF, 1'b0);
    chk("ram4", {16'd0, mem[4]}, 32'h0000BEEF);
    chk("ram5", {16'd0, mem[5]}, 32'h0000DEAD);
    access("rd_full", 1'b1, 1'b0, 32'd8, 4'h0, 32'd0, 1'b0);

    // Partial write via read-modify-write.
    access("preload", 1'b0, 1'b1, 32'd0, 4'hF, 32'h11223344, 1'b0);
    access("wr_rmw",  1'b0, 1'b1, 32'd0, 4'b0101, 32'hAABBCCDD, 1'b0);
    access("rd_rmw",  1'b1, 1'b0, 32'd0, 4'h0, 32'd0, 1'b0);
    chk("rmw_value", model_rd, 32'h11BB33DD);

    // Write with no enabled bytes: no RAM writes, readdata untouched.
    wr0 = wr_cnt;
    access("wr_be0", 1'b0, 1'b1, 32'd8, 4'h0, 32'h12345678, 1'b0);
    chk("be0_nowr", wr_cnt - wr0, 32'd0);

    // Misaligned read.
    rd0 = rd_cnt;
    access("misalign", 1'b1, 1'b0, 32'd2, 4'h0, 32'd0, 1'b0);
    chk("misalign_err", {31'd0, addr_error}, 32'd1);
    chk("misalign_nord", rd_cnt - rd0, 32'd0);

    // Out-of-range write at the last halfword.
    wr0 = wr_cnt;
    access("oob", 1'b0, 1'b1, 32'(2 * DEPTH - 2), 4'hF, 32'h55667788, 1'b0);
    chk("oob_err", {31'd0, addr_error}, 32'd1);
    chk("oob_nowr", wr_cnt - wr0, 32'd0);
    chk("oob_mem", {16'd0, mem[DEPTH - 1]}, {16'd0, ref_mem[DEPTH - 1]});

    // Reset during the HI cycle of a write.
    address    = BASE + 32'h100;
    write      = 1'b1;
    byteenable = 4'hF;
    writedata  = 32'hCAFEF00D;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rmid_nowr", {31'd0, ram_write}, 32'd0);
    chk("rmid_wait", {31'd0, waitrequest}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    write = 1'b0;
    @(negedge clk);
    chk("rmid_lo",    {16'd0, mem[32'h80]}, 32'h0000F00D);
    chk("rmid_hi",    {16'd0, mem[32'h81]}, 32'h00000000);
    chk("rmid_rdata", readdata, 32'd0);
    chk("rmid_err",   {31'd0, addr_error}, 32'd0);
    chk("rmid_ram",   {29'd0, ram_read, ram_write, |ram_address}, 32'd0);
    chk("rmid_wait2", {31'd0, waitrequest}, 32'd0);
    ref_mem[32'h80] = 16'hF00D;
    model_rd        = 32'd0;
    @(posedge clk);
    #1;
    access("rd_after_rst", 1'b1, 1'b0, 32'h100, 4'h0, 32'd0, 1'b0);

    // Back-to-back reads with read held high.
    access("b2b_a", 1'b1, 1'b0, 32'd8, 4'h0, 32'd0, 1'b1);
    t1 = last_done_t;
    access("b2b_b", 1'b1, 1'b0, 32'd0, 4'h0, 32'd0, 1'b0);
    chk("b2b_gap", 32'(last_done_t - t1), 32'd40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
